// File: rtl/reg_bus_master.sv
// ---------------------------------------------------------------------------
// reg_bus_master
//   Upstream bus master for reg_ctrl. Takes one register read/write command at
//   a time on a valid/ready request channel, drives the reg_ctrl bus until the
//   transfer completes or a ready-timeout fires, and returns the result on a
//   valid/ready response channel.
//
// Ports
//   clk, rstn                      clock (rising edge), async active-low reset
//   req_valid/req_ready            command handshake
//   req_wr, req_addr, req_wdata    command type, register address, write data
//   rsp_valid/rsp_ready            response handshake
//   rsp_wr, rsp_rdata, rsp_err     echoed type, read data (0 for writes and
//                                  aborts), timeout abort flag
//   sel, wr, addr, wdata           reg_ctrl bus outputs
//   rdata, ready                   reg_ctrl bus inputs
// ---------------------------------------------------------------------------
module reg_bus_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_wr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  sel,
    output logic                  wr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  ready
);

    localparam int                CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RDCAP,
        ST_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_wr_q, rsp_wr_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    // NOTE: every register here is a plain flop, so all of them take the async
    // reset; a reset mid-transfer drops sel at once because sel is decoded from
    // the state, and the in-flight command is simply forgotten.
    // NOTE: non-blocking assignments only in the clocked block, so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first so no path through the case leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ready wins over the timeout, so a ready arriving on the very
                // last allowed cycle still completes normally.
                if (ready) begin
                    rsp_wr_d    = wr_q;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = wr_q ? ST_RESP : ST_RDCAP;
                end else if (cnt_q == CNT_MAX) begin
                    rsp_wr_d    = wr_q;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    // Abort fires at CNT_MAX, so the count never passes it.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RDCAP: begin
                // reg_ctrl presents read data one cycle after it accepted sel.
                rsp_rdata_d = rdata;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and select outputs decode the state only: no combinational
    // path from req_* or rsp_ready to any output.
    assign req_ready = (state_q == ST_IDLE);
    assign sel       = (state_q == ST_BUS);
    assign rsp_valid = (state_q == ST_RESP);
    assign wr        = wr_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_master
//   Self-checking bench for reg_bus_master. A behavioural reg_ctrl slave with
//   a programmable ready stall answers the bus; a separate reference register
//   array plus timing rules predicts every response and its latency.
//   Latency is counted in clock edges, the accepting edge being edge 1.
// ---------------------------------------------------------------------------
module tb_reg_bus_master;

    localparam int AW      = 8;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid, req_ready, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_wr, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          sel, wr, ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;

    reg_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_wr    (rsp_wr),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .sel       (sel),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    // Slave register file (the reg_ctrl stand-in) and the reference copy.
    logic [DW-1:0] slave_mem [256];
    logic [DW-1:0] ref_mem   [256];

    int stall_cycles = 0;   // sel cycles the slave waits before raising ready
    int sel_cycles   = 0;   // consecutive cycles sel has been seen high
    int sel_hi       = 0;   // sel-high cycles since the last issue
    bit accepted, handshook;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: remember pre-edge handshakes, cross the edge, then update the
    // slave model and drive the next ready.
    task automatic tick();
        bit            acc, hs, xfer, p_wr;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata;
        acc     = req_valid && req_ready;
        hs      = rsp_valid && rsp_ready;
        xfer    = sel && ready;
        p_wr    = wr;
        p_addr  = addr;
        p_wdata = wdata;
        @(posedge clk);
        #1;
        if (xfer) begin
            if (p_wr) slave_mem[p_addr] = p_wdata;
            else      rdata = slave_mem[p_addr];
        end
        accepted  = acc;
        handshook = hs;
        if (sel) begin
            sel_cycles++;
            sel_hi++;
        end else begin
            sel_cycles = 0;
        end
        ready = sel && (sel_cycles > stall_cycles);
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output bit ok);
        int n;
        req_valid = 1'b1;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
        sel_hi    = 0;
        n         = 0;
        accepted  = 1'b0;
        while (!accepted && n < 50) begin
            tick();
            n++;
        end
        req_valid = 1'b0;
        req_wr    = ~w;
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
        ok = accepted;
        if (!ok) begin
            check("accept_bound", 32'd0, 32'd1);
        end else begin
            check("bus_sel", 32'(sel), 32'd1);
            check("bus_wr", 32'(wr), 32'(w));
            check("bus_addr", 32'(addr), 32'(a));
            if (w) check("bus_wdata", 32'(wdata), 32'(d));
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!rsp_valid) check("rsp_bound", 32'd0, 32'd1);
    endtask

    task automatic finish_rsp(input int dly);
        rsp_ready = 1'b0;
        for (int i = 0; i < dly; i++) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_handshake", 32'(handshook), 32'd1);
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    // Predict the outcome from the rules: ready appears on sel cycle stall+1;
    // sel may stay high at most TIMEOUT cycles; writes answer one edge after
    // completion, reads two; an abort answers at edge TIMEOUT+1.
    task automatic run_txn(input string tag, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int stall, input int rdly);
        bit            ok, exp_err;
        int            lat, exp_lat, exp_sel;
        logic [DW-1:0] exp_rd;
        exp_err = (stall + 1 > TIMEOUT);
        exp_rd  = (w || exp_err) ? '0 : ref_mem[a];
        if (w && !exp_err) ref_mem[a] = d;
        exp_lat = exp_err ? TIMEOUT + 1 : stall + 1 + (w ? 1 : 2);
        exp_sel = exp_err ? TIMEOUT : stall + 1;
        stall_cycles = stall;
        issue(w, a, d, ok);
        if (!ok) return;
        wait_rsp(lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_sel_cycles"}, 32'(sel_hi), 32'(exp_sel));
        check({tag, "_rsp_wr"}, 32'(rsp_wr), 32'(w));
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
        finish_rsp(rdly);
    endtask

    initial begin
        bit            ok;
        int            lat;
        logic [DW-1:0] v, exp_rd;

        for (int i = 0; i < 256; i++) begin
            v            = DW'($urandom);
            slave_mem[i] = v;
            ref_mem[i]   = v;
        end
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        ready     = 1'b0;
        rdata     = '0;

        // Reset state
        tick();
        tick();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_rsp_fields", {rsp_rdata, 14'd0, rsp_wr, rsp_err}, 32'd0);
        rstn = 1'b1;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // 1: write, 2: read back, no stall
        run_txn("t1_write", 1'b1, 8'h03, 16'hBEEF, 0, 0);
        run_txn("t2_read", 1'b0, 8'h03, 16'h0000, 0, 0);
        check("t2_data", 32'(rsp_rdata), 32'hBEEF);

        // 3: ready never comes -> abort; read so rdata=0 is meaningful
        run_txn("t3_timeout", 1'b0, 8'h03, 16'h0000, 1000, 0);
        // ready on the last allowed sel cycle still completes
        run_txn("t3_edge_wr", 1'b1, 8'h44, 16'h5A5A, TIMEOUT - 1, 0);
        run_txn("t3_edge_rd", 1'b0, 8'h44, 16'h0000, 0, 0);

        // 4: response back-pressure with a new request pending
        stall_cycles = 0;
        ref_mem[8'h10] = 16'h1234;
        issue(1'b1, 8'h10, 16'h1234, ok);
        wait_rsp(lat);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 8'h10;
        req_wdata = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
            check("t4_rsp_hold", {rsp_rdata, 14'd0, rsp_wr, rsp_err}, {16'h0000, 14'd0, 1'b1, 1'b0});
            check("t4_req_ready", 32'(req_ready), 32'd0);
            check("t4_no_accept", 32'(accepted), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t4_handshake", 32'(handshook), 32'd1);
        check("t4_no_bypass", 32'(accepted), 32'd0);
        check("t4_req_ready_back", 32'(req_ready), 32'd1);
        sel_hi = 0;
        tick();
        check("t4_next_accept", 32'(accepted), 32'd1);
        req_valid = 1'b0;
        wait_rsp(lat);
        check("t4_read_latency", 32'(lat), 32'd3);
        check("t4_read_data", 32'(rsp_rdata), 32'h1234);
        finish_rsp(0);

        // 5: reset while sel is high; the write must be lost
        stall_cycles = 1000;
        issue(1'b1, 8'h20, ~ref_mem[8'h20], ok);
        tick();
        tick();
        check("t5_sel_before", 32'(sel), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("t5_sel_async", 32'(sel), 32'd0);
        check("t5_rsp_valid_async", 32'(rsp_valid), 32'd0);
        check("t5_addr_async", 32'(addr), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("t5_req_ready", 32'(req_ready), 32'd1);
        check("t5_no_rsp", 32'(rsp_valid), 32'd0);
        run_txn("t5_lost_check", 1'b0, 8'h20, 16'h0000, 0, 0);

        // 6: stalled read, then random back-to-back commands
        run_txn("t6_stall_rd", 1'b0, 8'h03, 16'h0000, 2, 0);
        check("t6_stall_data", 32'(rsp_rdata), 32'hBEEF);
        for (int i = 0; i < 10; i++) begin
            run_txn("t6_rand", 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                    DW'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        // read every hot address back against the reference array
        for (int a = 0; a < 8; a++) begin
            exp_rd = ref_mem[a];
            run_txn("t6_sweep", 1'b0, AW'(a), 16'h0000, 2, 0);
            check("t6_sweep_data", 32'(rsp_rdata), 32'(exp_rd));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
